// File: rtl/lsu_mem_stage.sv
// Single-outstanding load/store unit in front of the byte-addressed data memory.
// Classifies each request, drives registered memory ports for one ACC cycle, and serves LED/switch I/O.
module lsu_mem_stage #(
  parameter int unsigned DM_BYTES = 1024,
  parameter logic [31:0] LED_ADDR = 32'h400,
  parameter logic [31:0] SW_ADDR  = 32'h404,
  parameter int unsigned IO_W     = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  input  logic            req_we,
  input  logic [2:0]      req_ctrl,
  input  logic [4:0]      req_rd,
  output logic [31:0]     Address,
  output logic [31:0]     DataWr,
  output logic            DMWr,
  output logic [2:0]      DMCtrl,
  input  logic [31:0]     DataRd,
  input  logic [IO_W-1:0] sw,
  output logic [IO_W-1:0] Leds,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [31:0]     wb_data,
  output logic [4:0]      wb_rd,
  output logic            exc_valid,
  output logic [3:0]      exc_cause,
  output logic [31:0]     exc_addr
);

  localparam logic [2:0] CtrlB  = 3'b000;
  localparam logic [2:0] CtrlH  = 3'b001;
  localparam logic [2:0] CtrlW  = 3'b010;
  localparam logic [2:0] CtrlBu = 3'b100;
  localparam logic [2:0] CtrlHu = 3'b101;

  localparam logic [3:0] CauseIllegal  = 4'd2;
  localparam logic [3:0] CauseLdAlign  = 4'd4;
  localparam logic [3:0] CauseLdFault  = 4'd5;
  localparam logic [3:0] CauseStAlign  = 4'd6;
  localparam logic [3:0] CauseStFault  = 4'd7;

  typedef enum logic [1:0] {StIdle, StAcc, StResp} state_e;
  typedef enum logic [1:0] {TgtDm, TgtLed, TgtSw} tgt_e;

  state_e          state_q, state_d;
  tgt_e            tgt_q, tgt_d;
  logic [31:0]     address_q, address_d;
  logic [31:0]     data_wr_q, data_wr_d;
  logic            dm_wr_q, dm_wr_d;
  logic [2:0]      dm_ctrl_q, dm_ctrl_d;
  logic [IO_W-1:0] leds_q, leds_d;
  logic [IO_W-1:0] io_wdata_q, io_wdata_d;
  logic            acc_we_q, acc_we_d;
  logic [31:0]     wb_data_q, wb_data_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic            exc_valid_q, exc_valid_d;
  logic [3:0]      exc_cause_q, exc_cause_d;
  logic [31:0]     exc_addr_q, exc_addr_d;

  logic       ctrl_legal, is_half, is_word, misaligned;
  logic       is_led, is_sw, in_dm, fault, req_exc;
  logic [3:0] req_cause;

  // Request classification; illegal beats misaligned beats fault.
  always_comb begin
    is_led  = (req_addr == LED_ADDR);
    is_sw   = (req_addr == SW_ADDR);
    in_dm   = (req_addr < DM_BYTES);
    is_half = (req_ctrl == CtrlH) || (req_ctrl == CtrlHu);
    is_word = (req_ctrl == CtrlW);
    case (req_ctrl)
      CtrlB, CtrlH, CtrlW: ctrl_legal = 1'b1;
      CtrlBu, CtrlHu:      ctrl_legal = !req_we;
      default:             ctrl_legal = 1'b0;
    endcase
    misaligned = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
    fault      = (!in_dm && !is_led && !is_sw)
              || ((is_led || is_sw) && !is_word)
              || (is_sw && req_we);
    req_exc    = !ctrl_legal || misaligned || fault;
    if (!ctrl_legal) begin
      req_cause = CauseIllegal;
    end else if (misaligned) begin
      req_cause = req_we ? CauseStAlign : CauseLdAlign;
    end else if (fault) begin
      req_cause = req_we ? CauseStFault : CauseLdFault;
    end else begin
      req_cause = 4'd0;
    end
  end

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    address_d   = address_q;
    data_wr_d   = data_wr_q;
    dm_wr_d     = dm_wr_q;
    dm_ctrl_d   = dm_ctrl_q;
    leds_d      = leds_q;
    io_wdata_d  = io_wdata_q;
    acc_we_d    = acc_we_q;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    exc_valid_d = exc_valid_q;
    exc_cause_d = exc_cause_q;
    exc_addr_d  = exc_addr_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          wb_rd_d = req_rd;
          if (req_exc) begin
            // Exceptions skip ACC so the memory never sees them.
            exc_valid_d = 1'b1;
            exc_cause_d = req_cause;
            exc_addr_d  = req_addr;
            wb_data_d   = '0;
            state_d     = StResp;
          end else begin
            exc_valid_d = 1'b0;
            exc_cause_d = '0;
            exc_addr_d  = '0;
            address_d   = req_addr;
            dm_ctrl_d   = req_ctrl;
            acc_we_d    = req_we;
            state_d     = StAcc;
            if (is_led) begin
              tgt_d      = TgtLed;
              io_wdata_d = req_wdata[IO_W-1:0];
            end else if (is_sw) begin
              tgt_d = TgtSw;
            end else begin
              tgt_d     = TgtDm;
              data_wr_d = req_wdata;
              dm_wr_d   = req_we;
            end
          end
        end
      end
      StAcc: begin
        dm_wr_d = 1'b0;
        state_d = StResp;
        if (acc_we_q) begin
          wb_data_d = '0;
          if (tgt_q == TgtLed) begin
            leds_d = io_wdata_q;
          end
        end else begin
          case (tgt_q)
            TgtLed:  wb_data_d = 32'(leds_q);
            TgtSw:   wb_data_d = 32'(sw);
            default: wb_data_d = DataRd;
          endcase
        end
      end
      StResp: begin
        if (wb_ready) begin
          exc_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      tgt_q       <= TgtDm;
      address_q   <= '0;
      data_wr_q   <= '0;
      dm_wr_q     <= 1'b0;
      dm_ctrl_q   <= '0;
      leds_q      <= '0;
      io_wdata_q  <= '0;
      acc_we_q    <= 1'b0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= '0;
      exc_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      address_q   <= address_d;
      data_wr_q   <= data_wr_d;
      dm_wr_q     <= dm_wr_d;
      dm_ctrl_q   <= dm_ctrl_d;
      leds_q      <= leds_d;
      io_wdata_q  <= io_wdata_d;
      acc_we_q    <= acc_we_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      exc_valid_q <= exc_valid_d;
      exc_cause_q <= exc_cause_d;
      exc_addr_q  <= exc_addr_d;
    end
  end

  assign req_ready = rst_n && (state_q == StIdle);
  assign wb_valid  = (state_q == StResp);
  assign Address   = address_q;
  assign DataWr    = data_wr_q;
  assign DMWr      = dm_wr_q;
  assign DMCtrl    = dm_ctrl_q;
  assign Leds      = leds_q;
  assign wb_data   = wb_data_q;
  assign wb_rd     = wb_rd_q;
  assign exc_valid = exc_valid_q;
  assign exc_cause = exc_cause_q;
  assign exc_addr  = exc_addr_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: a transaction-level reference model plus a small data memory,
// compared against the DUT every cycle under directed and random traffic.
module tb_lsu_mem_stage;
  localparam int unsigned DM_BYTES = 1024;
  localparam logic [31:0] LED_ADDR = 32'h400;
  localparam logic [31:0] SW_ADDR  = 32'h404;
  localparam int unsigned IO_W     = 10;
  localparam logic [2:0]  B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0]     req_addr = '0, req_wdata = '0;
  logic [2:0]      req_ctrl = '0;
  logic [4:0]      req_rd = '0;
  logic [31:0]     Address, DataWr, DataRd;
  logic            DMWr;
  logic [2:0]      DMCtrl;
  logic [IO_W-1:0] sw = '0, Leds;
  logic            wb_valid, wb_ready = 1'b1, exc_valid;
  logic [31:0]     wb_data, exc_addr;
  logic [4:0]      wb_rd;
  logic [3:0]      exc_cause;

  int n_checks = 0;
  int n_errors = 0;
  bit rand_sw  = 1'b1;

  always #5 clk = ~clk;

  lsu_mem_stage #(.DM_BYTES(DM_BYTES), .LED_ADDR(LED_ADDR), .SW_ADDR(SW_ADDR), .IO_W(IO_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we), .req_ctrl(req_ctrl),
    .req_rd(req_rd), .Address(Address), .DataWr(DataWr), .DMWr(DMWr), .DMCtrl(DMCtrl),
    .DataRd(DataRd), .sw(sw), .Leds(Leds), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_addr(exc_addr)
  );

  // Data memory: combinational read with extension, write on the edge while DMWr is high.
  logic [31:0] dev_mem [256] = '{default: '0};
  logic [31:0] rd_word, rd_shift;
  always_comb begin
    rd_word  = dev_mem[Address[9:2]];
    rd_shift = rd_word >> {Address[1:0], 3'b000};
    case (DMCtrl)
      B:       DataRd = {{24{rd_shift[7]}}, rd_shift[7:0]};
      BU:      DataRd = {24'h0, rd_shift[7:0]};
      H:       DataRd = {{16{rd_shift[15]}}, rd_shift[15:0]};
      HU:      DataRd = {16'h0, rd_shift[15:0]};
      default: DataRd = rd_word;
    endcase
  end
  always @(posedge clk) begin
    if (DMWr) begin
      case (DMCtrl[1:0])
        2'b00:   dev_mem[Address[9:2]][{Address[1:0], 3'b000} +: 8] <= DataWr[7:0];
        2'b01:   dev_mem[Address[9:2]][{Address[1], 4'b0000} +: 16] <= DataWr[15:0];
        default: dev_mem[Address[9:2]] <= DataWr;
      endcase
    end
  end

  // Reference model state
  logic [7:0]      ref_mem [DM_BYTES] = '{default: '0};
  logic [IO_W-1:0] ref_leds = '0, m_led_val = '0;
  bit              m_acc = 0, m_resp = 0, m_dmwr = 0, m_led_pend = 0, m_sw_load = 0;
  logic [31:0]     m_addr = '0, m_wdata = '0, m_rsp_data = '0, m_rsp_eaddr = '0;
  logic [2:0]      m_ctrl = '0;
  logic [4:0]      m_rsp_rd = '0;
  bit              m_rsp_exc = 0;
  logic [3:0]      m_rsp_cause = '0;

  function automatic int unsigned size_of(logic [2:0] c);
    return (c[1:0] == 2'b00) ? 1 : (c[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [3:0] classify(logic [31:0] a, logic we, logic [2:0] c);
    bit legal, io, ok;
    int unsigned sz;
    legal = we ? (c inside {B, H, W}) : (c inside {B, H, W, BU, HU});
    sz    = size_of(c);
    io    = (a == LED_ADDR) || (a == SW_ADDR);
    if (!legal) return 4'd2;
    if ((a % sz) != 0) return we ? 4'd6 : 4'd4;
    ok = io ? (sz == 4 && !(we && a == SW_ADDR)) : (a < DM_BYTES);
    if (!ok) return we ? 4'd7 : 4'd5;
    return 4'd0;
  endfunction

  function automatic logic [31:0] dm_load(logic [31:0] a, logic [2:0] c);
    logic [31:0] v;
    int unsigned sz;
    sz = size_of(c);
    v  = '0;
    for (int b = 0; b < int'(sz); b++) v[8*b +: 8] = ref_mem[(a + 32'(b)) % DM_BYTES];
    if (!c[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
    if (!c[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic model_step();
    logic [3:0] cause;
    int unsigned sz;
    if (!rst_n) begin
      m_acc = 0; m_resp = 0; m_dmwr = 0; m_led_pend = 0; ref_leds = '0;
      return;
    end
    m_dmwr = 0;
    if (m_resp) begin
      if (wb_ready) m_resp = 0;
    end else if (m_acc) begin
      m_acc  = 0;
      m_resp = 1;
      if (m_sw_load) m_rsp_data = 32'(sw);
      if (m_led_pend) begin ref_leds = m_led_val; m_led_pend = 0; end
    end else if (req_valid) begin
      cause      = classify(req_addr, req_we, req_ctrl);
      m_rsp_rd   = req_rd;
      m_rsp_data = '0;
      m_sw_load  = 0;
      if (cause != 0) begin
        m_resp = 1; m_rsp_exc = 1; m_rsp_cause = cause; m_rsp_eaddr = req_addr;
      end else begin
        m_acc = 1; m_rsp_exc = 0;
        if (req_addr == LED_ADDR) begin
          if (req_we) begin m_led_pend = 1; m_led_val = req_wdata[IO_W-1:0]; end
          else m_rsp_data = 32'(ref_leds);
        end else if (req_addr == SW_ADDR) begin
          m_sw_load = 1;
        end else if (req_we) begin
          m_dmwr = 1; m_addr = req_addr; m_wdata = req_wdata; m_ctrl = req_ctrl;
          sz = size_of(req_ctrl);
          for (int b = 0; b < int'(sz); b++)
            ref_mem[(req_addr + 32'(b)) % DM_BYTES] = req_wdata[8*b +: 8];
        end else begin
          m_rsp_data = dm_load(req_addr, req_ctrl);
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  task automatic compare();
    chk("req_ready", 32'(req_ready), 32'(rst_n && !m_acc && !m_resp));
    chk("DMWr", 32'(DMWr), 32'(m_dmwr));
    if (m_dmwr) begin
      chk("Address", Address, m_addr);
      chk("DataWr", DataWr, m_wdata);
      chk("DMCtrl", 32'(DMCtrl), 32'(m_ctrl));
    end
    chk("wb_valid", 32'(wb_valid), 32'(m_resp));
    if (m_resp) begin
      chk("wb_data", wb_data, m_rsp_data);
      chk("wb_rd", 32'(wb_rd), 32'(m_rsp_rd));
      chk("exc_valid", 32'(exc_valid), 32'(m_rsp_exc));
      if (m_rsp_exc) begin
        chk("exc_cause", 32'(exc_cause), 32'(m_rsp_cause));
        chk("exc_addr", exc_addr, m_rsp_eaddr);
      end
    end
    chk("Leds", 32'(Leds), 32'(ref_leds));
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_step();
    #2;
    if (rand_sw) sw = IO_W'($urandom);
  endtask

  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic we,
                        input logic [2:0] c, input logic [4:0] rd);
    logic acc;
    bit done;
    done = 0;
    req_addr = a; req_wdata = d; req_we = we; req_ctrl = c; req_rd = rd; req_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      acc = req_ready;
      tick();
      done = acc;
    end
    req_valid = 1'b0;
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL accept_timeout: req_ready never seen, got 0, expected 1");
    end
  endtask

  task automatic get_resp(output logic [31:0] d, output logic [4:0] rd, output logic ev,
                          output logic [3:0] c, output logic [31:0] ea);
    bit got;
    got = 0; d = '0; rd = '0; ev = 1'b0; c = '0; ea = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (wb_valid) begin
        d = wb_data; rd = wb_rd; ev = exc_valid; c = exc_cause; ea = exc_addr; got = 1;
      end
      tick();
    end
    if (!got) begin
      n_checks++; n_errors++;
      $display("FAIL resp_timeout: wb_valid never seen, got 0, expected 1");
    end
  endtask

  logic [31:0] r_d, r_ea;
  logic [4:0]  r_rd;
  logic        r_ev;
  logic [3:0]  r_c;
  logic [2:0]  ctrl_tab [5] = '{B, H, W, BU, HU};

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_Address", Address, 32'h0);
    chk("rst_DataWr", DataWr, 32'h0);
    chk("rst_DMWr", 32'(DMWr), 32'h0);
    chk("rst_DMCtrl", 32'(DMCtrl), 32'h0);
    chk("rst_Leds", 32'(Leds), 32'h0);
    chk("rst_wb_valid", 32'(wb_valid), 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_exc_valid", 32'(exc_valid), 32'h0);
    chk("rst_exc_cause", 32'(exc_cause), 32'h0);
    chk("rst_exc_addr", exc_addr, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(req_ready), 32'h1);

    // Word store then load
    do_req(32'h10, 32'hDEADBEEF, 1'b1, W, 5'd1);
    chk("st_dmwr", 32'(DMWr), 32'h1);
    chk("st_addr", Address, 32'h10);
    chk("st_ctrl", 32'(DMCtrl), 32'(W));
    chk("st_wdata", DataWr, 32'hDEADBEEF);
    tick();
    chk("st_dmwr_drop", 32'(DMWr), 32'h0);
    get_resp(r_d, r_rd, r_ev, r_c, r_ea);
    chk("st_resp_data", r_d, 32'h0);
    do_req(32'h10, 32'h0, 1'b0, W, 5'd7);
    chk("ld_acc_no_valid", 32'(wb_valid), 32'h0);
    get_resp(r_d, r_rd, r_ev, r_c, r_ea);
    chk("ldw_data", r_d, 32'hDEADBEEF);
    chk("ldw_rd", 32'(r_rd), 32'd7);
    chk("ldw_exc", 32'(r_ev), 32'h0);

    // Byte store, signed and unsigned loads
    do_req(32'h21, 32'h80, 1'b1, B, 5'd2);
    get_resp(r_d, r_rd, r_ev, r_c, r_ea);
    do_req(32'h21, 32'h0, 1'b0, B, 5'd3);
    get_resp(r_d, r_rd, r_ev, r_c, r_ea);
    chk("ldb_data", r_d, 32'hFFFFFF80);
    do_req(32'h21, 32'h0, 1'b0, BU, 5'd4);
    get_resp(r_d, r_rd, r_ev, r_c, r_ea);
    chk("ldbu_data", r_d, 32'h00000080);

    // Exceptions
    do_req(32'h13, 32'h0, 1'b0, H, 5'd4);
    chk("exc_fast_valid", 32'(wb_valid), 32'h1);
    chk("exc_no_dmwr", 32'(DMWr), 32'h0);
    get_resp(r_d, r_rd, r_ev, r_c, r_ea);
    chk("ldh_mis_exc", 32'(r_ev), 32'h1);
    chk("ldh_mis_cause", 32'(r_c), 32'd4);
    chk("ldh_mis_addr", r_ea, 32'h13);
    chk("ldh_mis_data", r_d, 32'h0);
    do_req(32'h3FE, 32'h1, 1'b1, W, 5'd5);
    get_resp(r_d, r_rd, r_ev, r_c, r_ea);
    chk("stw_mis_cause", 32'(r_c), 32'd6);
    do_req(32'h10, 32'h1, 1'b1, BU, 5'd6);
    get_resp(r_d, r_rd, r_ev, r_c, r_ea);
    chk("st_illegal_cause", 32'(r_c), 32'd2);

    // LED and switch I/O
    rand_sw = 1'b0;
    sw = 10'b1010101010;
    do_req(LED_ADDR, 32'h2AA, 1'b1, W, 5'd8);
    chk("led_in_acc", 32'(Leds), 32'h0);
    tick();
    chk("led_after_acc", 32'(Leds), 32'h2AA);
    get_resp(r_d, r_rd, r_ev, r_c, r_ea);
    do_req(SW_ADDR, 32'h0, 1'b0, W, 5'd9);
    get_resp(r_d, r_rd, r_ev, r_c, r_ea);
    chk("sw_load", r_d, 32'h2AA);
    do_req(LED_ADDR, 32'h0, 1'b0, W, 5'd10);
    get_resp(r_d, r_rd, r_ev, r_c, r_ea);
    chk("led_load", r_d, 32'h2AA);
    do_req(SW_ADDR, 32'h5, 1'b1, W, 5'd11);
    get_resp(r_d, r_rd, r_ev, r_c, r_ea);
    chk("sw_store_cause", 32'(r_c), 32'd7);
    do_req(32'h800, 32'h0, 1'b0, W, 5'd12);
    get_resp(r_d, r_rd, r_ev, r_c, r_ea);
    chk("ld_fault_cause", 32'(r_c), 32'd5);
    do_req(LED_ADDR, 32'h0, 1'b0, B, 5'd13);
    get_resp(r_d, r_rd, r_ev, r_c, r_ea);
    chk("led_byte_cause", 32'(r_c), 32'd5);
    rand_sw = 1'b1;

    // Backpressure on the response
    wb_ready = 1'b0;
    do_req(32'h10, 32'h0, 1'b0, W, 5'd9);
    tick();
    req_addr = 32'h24; req_wdata = 32'h12345678; req_we = 1'b1; req_ctrl = W; req_rd = 5'd10;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(wb_valid), 32'h1);
      chk("hold_ready", 32'(req_ready), 32'h0);
      chk("hold_data", wb_data, 32'hDEADBEEF);
      chk("hold_rd", 32'(wb_rd), 32'd9);
      tick();
    end
    wb_ready = 1'b1;
    chk("pre_hs_ready", 32'(req_ready), 32'h0);
    tick();
    chk("post_hs_valid", 32'(wb_valid), 32'h0);
    chk("post_hs_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 1'b0;
    chk("second_dmwr", 32'(DMWr), 32'h1);
    chk("second_addr", Address, 32'h24);
    get_resp(r_d, r_rd, r_ev, r_c, r_ea);

    // Reset in the middle of a store's ACC cycle
    do_req(32'h30, 32'hCAFE0000, 1'b1, W, 5'd3);
    chk("rst_acc_dmwr_pre", 32'(DMWr), 32'h1);
    rst_n = 1'b0;
    tick();
    chk("rst_acc_dmwr", 32'(DMWr), 32'h0);
    chk("rst_acc_wb_valid", 32'(wb_valid), 32'h0);
    chk("rst_acc_leds", 32'(Leds), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rst_acc_ready", 32'(req_ready), 32'h1);

    // Random traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0, 1, 2: req_addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00}
                            | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'h0);
        3:       req_addr = 32'($urandom_range(DM_BYTES - 8, DM_BYTES - 1));
        4:       req_addr = LED_ADDR;
        5:       req_addr = SW_ADDR;
        6:       req_addr = 32'h800 | 32'($urandom_range(0, 7));
        default: req_addr = $urandom;
      endcase
      req_ctrl  = ($urandom_range(0, 9) < 8) ? ctrl_tab[$urandom_range(0, 4)]
                                             : 3'($urandom_range(0, 7));
      req_we    = 1'($urandom_range(0, 1));
      req_wdata = $urandom;
      req_rd    = 5'($urandom_range(0, 31));
      wb_ready  = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 299) != 0);
      tick();
    end

    rst_n = 1'b1; req_valid = 1'b0; wb_ready = 1'b1;
    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
